// File: rtl/dm_decoder_param.sv
// -----------------------------------------------------------------------------
// dm_decoder_param
//
// Purpose:
//   Decodes a square N x N module matrix. The matrix is latched when a decode
//   is requested, the finder pattern is checked (top row alternating 01,
//   bottom row all ones), and the payload rows are then shifted one per
//   cycle into card_id. The result is flagged with id_valid, which stays set
//   until the consumer acknowledges it.
//
// Parameters:
//   N             matrix side in modules (even, 4..32)
//   PAYLOAD_ROW0  index of the first payload row (row 0 is the top row)
//   PAYLOAD_ROWS  number of payload rows
//
// Ports:
//   clk             in   1      rising-edge clock
//   reset           in   1      asynchronous, active-high reset
//   data_matrix_in  in   N*N    row r = bits [N*N-1-r*N -: N], MSB = leftmost
//   dm_decode_en    in   1      start request (honoured only when idle)
//   id_ack          in   1      consumer has taken card_id
//   busy            out  1      decode in progress (CHECK or EXTRACT)
//   decode_done     out  1      one-cycle completion pulse
//   decode_error    out  1      last decode produced no valid result
//   id_valid        out  1      card_id holds an unconsumed valid result
//   card_id         out  PAYLOAD_ROWS*N  payload, row PAYLOAD_ROW0 in the MSBs
//
// Configuration macro:
//   DM_PARITY_CHECK_EN  when defined, every payload row must have even
//                       popcount; the first odd row aborts the decode with
//                       decode_error set.
//
// States:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for dm_decode_en; matrix captured on acceptance
//   S_CHECK   | finder pattern test on the captured matrix
//   S_EXTRACT | one payload row shifted into card_id per cycle
//   S_DONE    | result published with decode_done on the exit edge
// -----------------------------------------------------------------------------
module dm_decoder_param #(
    parameter int N            = 16,
    parameter int PAYLOAD_ROW0 = 1,
    parameter int PAYLOAD_ROWS = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N*N-1:0]            data_matrix_in,
    input  logic                      dm_decode_en,
    input  logic                      id_ack,
    output logic                      busy,
    output logic                      decode_done,
    output logic                      decode_error,
    output logic                      id_valid,
    output logic [PAYLOAD_ROWS*N-1:0] card_id
);

    localparam int CW = PAYLOAD_ROWS * N;
    localparam int RW = (PAYLOAD_ROWS > 1) ? $clog2(PAYLOAD_ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(PAYLOAD_ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_EXTRACT,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [N*N-1:0]  r_matrix;
    logic [RW-1:0]   r_row;
    logic [CW-1:0]   r_card;
    logic            r_done;
    logic            r_error;
    logic            r_valid;
    logic            r_fail;

    logic [N-1:0]    w_row_data;
    logic            w_finder_ok;
    logic            w_row_bad;
    logic            w_last_row;

    // Finder pattern: top row alternates 0/1 starting with 0, bottom row solid.
    assign w_finder_ok = (r_matrix[N*N-1 -: N] == {(N/2){2'b01}}) &&
                         (r_matrix[N-1:0]      == {N{1'b1}});

    // Payload row mux. Every matrix row is a candidate so the selection stays
    // a plain constant-index mux; rows outside the payload are never matched.
    always_comb begin
        w_row_data = '0;
        for (int r = 0; r < N; r++) begin
            if (r == PAYLOAD_ROW0 + int'(r_row)) begin
                w_row_data = r_matrix[N*N-1-r*N -: N];
            end
        end
    end

`ifdef DM_PARITY_CHECK_EN
    // Even parity per row: any odd popcount marks the row as corrupt.
    assign w_row_bad = ^w_row_data;
`else
    assign w_row_bad = 1'b0;
`endif

    assign w_last_row = (r_row == LAST_ROW);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (dm_decode_en) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_next = w_finder_ok ? S_EXTRACT : S_DONE;
            end
            S_EXTRACT: begin
                if (w_row_bad || w_last_row) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and result flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_matrix <= '0;
            r_row    <= '0;
            r_card   <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_valid  <= 1'b0;
            r_fail   <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Consumer acknowledge; a result published on this same edge in
            // S_DONE below overrides it.
            if (id_ack) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (dm_decode_en) begin
                        r_matrix <= data_matrix_in;
                        r_row    <= '0;
                        r_card   <= '0;
                        r_valid  <= 1'b0;
                        r_error  <= 1'b0;
                        r_fail   <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (!w_finder_ok) begin
                        r_fail <= 1'b1;
                    end
                end
                S_EXTRACT: begin
                    r_card <= (r_card << N) | CW'(w_row_data);
                    if (w_row_bad) begin
                        r_fail <= 1'b1;
                    end
                    // Counter saturates on the last row instead of wrapping.
                    if (!w_last_row) begin
                        r_row <= r_row + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    if (r_fail) begin
                        r_error <= 1'b1;
                        r_valid <= 1'b0;
                        r_card  <= '0;
                    end else begin
                        r_error <= 1'b0;
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = (r_state == S_CHECK) || (r_state == S_EXTRACT);
    assign decode_done  = r_done;
    assign decode_error = r_error;
    assign id_valid     = r_valid;
    assign card_id      = r_card;

endmodule

// File: tb/tb_dm_decoder_param.sv
// -----------------------------------------------------------------------------
// tb_dm_decoder_param
//
// Directed bench for dm_decoder_param at default parameters. Edge 0 is the
// clock edge that accepts dm_decode_en; outputs are sampled 1 time unit after
// each rising edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_dm_decoder_param;

    localparam int N  = 16;
    localparam int PR = 10;
    localparam int CW = PR * N;

    localparam logic [255:0] M19 =
        256'h5555944D_6163971D_3EB9DAC5_30BFC435_14A9D1F5_15EB8A55_304581D7_0227FFFF;
    localparam logic [159:0] CARD19 =
        160'h944D6163971D3EB9DAC530BFC43514A9D1F515EB;
    localparam logic [255:0] M21 =
        256'hAAAA944D_6163971D_3EB9DAC5_30BFC435_14A9D1F5_15EB8A55_304581D7_0227FFFF;
    localparam logic [255:0] MBOT =
        256'h5555944D_6163971D_3EB9DAC5_30BFC435_14A9D1F5_15EB8A55_304581D7_0227FFFE;
    // Every payload row of MC has even popcount.
    localparam logic [255:0] MC =
        256'h5555_0000_0003_1111_FFFF_0101_8001_C3C3_0660_7E00_A005_1234_5678_9ABC_DEF0_FFFF;
    localparam logic [159:0] CARDC =
        160'h0000_0003_1111_FFFF_0101_8001_C3C3_0660_7E00_A005;

    logic                clk;
    logic                reset;
    logic [N*N-1:0]      data_matrix_in;
    logic                dm_decode_en;
    logic                id_ack;
    logic                busy;
    logic                decode_done;
    logic                decode_error;
    logic                id_valid;
    logic [CW-1:0]       card_id;

    int n_checks;
    int n_errors;

    dm_decoder_param #(
        .N            (N),
        .PAYLOAD_ROW0 (1),
        .PAYLOAD_ROWS (PR)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .data_matrix_in (data_matrix_in),
        .dm_decode_en   (dm_decode_en),
        .id_ack         (id_ack),
        .busy           (busy),
        .decode_done    (decode_done),
        .decode_error   (decode_error),
        .id_valid       (id_valid),
        .card_id        (card_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a decode at edge 0 and follows it to completion. The matrix input
    // is inverted right after capture to expose any re-sampling.
    task automatic run_decode(input string tag, input logic [255:0] m, input int exp_edge,
                              input logic exp_err, input logic [159:0] exp_card);
        int  k;
        int  seen;
        data_matrix_in = m;
        dm_decode_en   = 1'b1;
        step();
        dm_decode_en   = 1'b0;
        data_matrix_in = ~m;
        chk({tag, "_busy_e0"}, busy, 1'b1);
        chk({tag, "_valid_clr"}, id_valid, 1'b0);
        chk({tag, "_err_clr"}, decode_error, 1'b0);
        chk({tag, "_card_clr"}, card_id, '0);
        seen = 0;
        k    = 0;
        while (seen == 0 && k < 40) begin
            step();
            k++;
            if (decode_done) begin
                seen = k;
            end else begin
                chk({tag, "_busy"}, busy, (k < exp_edge - 1));
            end
        end
        chk({tag, "_done_edge"}, seen, exp_edge);
        chk({tag, "_err"}, decode_error, exp_err);
        chk({tag, "_valid"}, id_valid, !exp_err);
        chk({tag, "_card"}, card_id, exp_card);
        chk({tag, "_busy_done"}, busy, 1'b0);
        step();
        chk({tag, "_done_pulse"}, decode_done, 1'b0);
        chk({tag, "_err_hold"}, decode_error, exp_err);
    endtask

    initial begin
        int done_cnt;
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b1;
        data_matrix_in = '0;
        dm_decode_en   = 1'b0;
        id_ack         = 1'b0;

        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", decode_done, 1'b0);
        chk("rst_err", decode_error, 1'b0);
        chk("rst_valid", id_valid, 1'b0);
        chk("rst_card", card_id, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // First request after reset release, accepted on the very next edge.
`ifdef DM_PARITY_CHECK_EN
        run_decode("m19", M19, 3, 1'b1, '0);
`else
        run_decode("m19", M19, 12, 1'b0, CARD19);
`endif

        // Top finder row broken: straight to DONE, no extraction.
        run_decode("top_fail", M21, 2, 1'b1, '0);
        step();
        step();
        chk("err_sticky", decode_error, 1'b1);
        chk("valid_after_err", id_valid, 1'b0);

        // Bottom finder row broken.
        run_decode("bot_fail", MBOT, 2, 1'b1, '0);

        // Parity-clean matrix decodes in either build.
        run_decode("clean", MC, 12, 1'b0, CARDC);
        chk("valid_hold", id_valid, 1'b1);
        id_ack = 1'b1;
        step();
        id_ack = 1'b0;
        chk("ack_clears", id_valid, 1'b0);
        id_ack = 1'b1;
        step();
        id_ack = 1'b0;
        chk("ack_idle_noeffect", id_valid, 1'b0);
        chk("ack_idle_err", decode_error, 1'b0);

`ifdef DM_PARITY_CHECK_EN
        // Row index 3 (matrix row 4) has odd weight: abort at edge 6.
        run_decode("par_bad", {MC[255:192], 16'hFFFE, MC[175:0]}, 6, 1'b1, '0);
`else
        // Re-trigger at edge 5 ignored; ack at edge 12 loses to the new result.
        data_matrix_in = M19;
        dm_decode_en   = 1'b1;
        step();
        dm_decode_en   = 1'b0;
        done_cnt       = 0;
        for (int k = 1; k <= 14; k++) begin
            dm_decode_en = (k == 5);
            id_ack       = (k == 12) || (k == 14);
            step();
            if (decode_done) done_cnt++;
            if (k == 12) begin
                chk("rt_done12", decode_done, 1'b1);
                chk("rt_valid12", id_valid, 1'b1);
                chk("rt_card", card_id, CARD19);
            end
            if (k == 13) chk("rt_valid13", id_valid, 1'b1);
            if (k == 14) chk("rt_valid14", id_valid, 1'b0);
        end
        dm_decode_en = 1'b0;
        id_ack       = 1'b0;
        chk("rt_done_count", done_cnt, 1);

        // Reset mid-decode, just before edge 6.
        data_matrix_in = M19;
        dm_decode_en   = 1'b1;
        step();
        dm_decode_en   = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        chk("ab_busy_pre", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("ab_busy", busy, 1'b0);
        chk("ab_done", decode_done, 1'b0);
        chk("ab_err", decode_error, 1'b0);
        chk("ab_valid", id_valid, 1'b0);
        chk("ab_card", card_id, '0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (decode_done) done_cnt++;
        end
        chk("ab_no_done", done_cnt, 0);
        chk("ab_idle", busy, 1'b0);
        run_decode("after_abort", M19, 12, 1'b0, CARD19);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
